// File: rtl/aes_axis_pkg.sv
// Shared block geometry and helpers for the AES AXI-Stream front end.
package aes_axis_pkg;

  localparam int AES_BLOCK_W     = 128;
  localparam int AES_BLOCK_BYTES = 16;

  typedef logic [AES_BLOCK_W-1:0] aes_block_t;

  // Byte-valid mask for a block holding nbeats beats of in_w bits, MSB byte first.
  function automatic logic [15:0] keep_from_beats(input int unsigned nbeats, input int unsigned in_w);
    int unsigned nbytes;
    nbytes = (nbeats * in_w) / 32'd8;
    if (nbytes >= 32'(AES_BLOCK_BYTES)) begin
      return 16'hFFFF;
    end else begin
      return ~(16'hFFFF >> nbytes);
    end
  endfunction

endpackage

// File: rtl/aes_axis_block_packer.sv
// Packs a narrow AXI-Stream into 128-bit AES blocks, zero-padding a packet tail.
module aes_axis_block_packer
  import aes_axis_pkg::*;
#(
  parameter int IN_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            soft_clear,
  input  logic [IN_W-1:0] s_axis_tdata,
  input  logic            s_axis_tvalid,
  input  logic            s_axis_tlast,
  output logic            s_axis_tready,
  output logic [127:0]    m_axis_tdata,
  output logic [15:0]     m_axis_tkeep,
  output logic            m_axis_tvalid,
  output logic            m_axis_tlast,
  input  logic            m_axis_tready,
  output logic [31:0]     blk_count,
  output logic [15:0]     pad_count,
  output logic            busy
);

  localparam int WORDS = AES_BLOCK_W / IN_W;
  localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic [CW-1:0] beat_cnt_r;
  aes_block_t    acc_r;
  aes_block_t    tdata_r;
  logic [15:0]   tkeep_r;
  logic          tvalid_r;
  logic          tlast_r;
  logic [31:0]   blk_count_r;
  logic [15:0]   pad_count_r;

  logic          in_hs_s;
  logic          out_hs_s;
  logic          complete_s;
  logic [7:0]    shamt_s;
  aes_block_t    beat_top_s;
  aes_block_t    merged_s;

  // Handshakes and the accumulator with the current beat merged in.
  always_comb begin
    s_axis_tready = !soft_clear & (!tvalid_r | m_axis_tready);
    in_hs_s       = s_axis_tvalid & s_axis_tready;
    out_hs_s      = tvalid_r & m_axis_tready;
    complete_s    = in_hs_s & ((beat_cnt_r == CW'(WORDS - 1)) | s_axis_tlast);
    shamt_s       = 8'(beat_cnt_r) * 8'(IN_W);
    beat_top_s    = {s_axis_tdata, {(AES_BLOCK_W - IN_W){1'b0}}};
    merged_s      = acc_r | (beat_top_s >> shamt_s);
  end

  // Accumulator, beat counter and held output block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_r <= '0;
      acc_r      <= '0;
      tdata_r    <= '0;
      tkeep_r    <= 16'h0000;
      tvalid_r   <= 1'b0;
      tlast_r    <= 1'b0;
    end else if (soft_clear) begin
      beat_cnt_r <= '0;
      acc_r      <= '0;
      tdata_r    <= '0;
      tkeep_r    <= 16'h0000;
      tvalid_r   <= 1'b0;
      tlast_r    <= 1'b0;
    end else if (complete_s) begin
      // A completing beat may land on the same edge the old block drains.
      beat_cnt_r <= '0;
      acc_r      <= '0;
      tdata_r    <= merged_s;
      tkeep_r    <= keep_from_beats(32'(beat_cnt_r) + 32'd1, 32'(IN_W));
      tvalid_r   <= 1'b1;
      tlast_r    <= s_axis_tlast;
    end else begin
      if (in_hs_s) begin
        beat_cnt_r <= beat_cnt_r + CW'(1);
        acc_r      <= merged_s;
      end
      if (out_hs_s) begin
        tvalid_r <= 1'b0;
      end
    end
  end

  // Emitted-block statistics, advanced on the output handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_count_r <= 32'd0;
      pad_count_r <= 16'd0;
    end else if (soft_clear) begin
      blk_count_r <= 32'd0;
      pad_count_r <= 16'd0;
    end else if (out_hs_s) begin
      blk_count_r <= blk_count_r + 32'd1;
      if ((tkeep_r != 16'hFFFF) && (pad_count_r != 16'hFFFF)) begin
        pad_count_r <= pad_count_r + 16'd1;
      end
    end
  end

  assign m_axis_tdata  = tdata_r;
  assign m_axis_tkeep  = tkeep_r;
  assign m_axis_tvalid = tvalid_r;
  assign m_axis_tlast  = tlast_r;
  assign blk_count     = blk_count_r;
  assign pad_count     = pad_count_r;
  assign busy          = (beat_cnt_r != '0) | tvalid_r;

endmodule

// File: tb/tb_aes_axis_block_packer.sv
// Scoreboard bench for the block packer: a 32-bit and an 8-bit instance.
module tb_aes_axis_block_packer;

  typedef struct packed {
    logic [127:0] d;
    logic [15:0]  k;
    logic         l;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic soft_clear = 1'b0;

  logic [31:0]  a_tdata = 32'd0;
  logic         a_tvalid = 1'b0, a_tlast = 1'b0, a_tready;
  logic [127:0] a_m_tdata;
  logic [15:0]  a_m_tkeep;
  logic         a_m_tvalid, a_m_tlast, a_m_tready = 1'b1;
  logic [31:0]  a_blk;
  logic [15:0]  a_pad;
  logic         a_busy;

  logic [7:0]   b_tdata = 8'd0;
  logic         b_tvalid = 1'b0, b_tlast = 1'b0, b_tready;
  logic [127:0] b_m_tdata;
  logic [15:0]  b_m_tkeep;
  logic         b_m_tvalid, b_m_tlast, b_m_tready = 1'b1;
  logic [31:0]  b_blk;
  logic [15:0]  b_pad;
  logic         b_busy;

  int n_checks = 0;
  int n_errors = 0;

  exp_t q32[$];
  exp_t q8[$];
  logic [127:0] acc32 = '0, acc8 = '0;
  int k32 = 0, k8 = 0;
  int cyc32 = 0, prev32 = 0;
  logic gap_en = 1'b0, gap_ok = 1'b0;

  always #5 clk = ~clk;

  aes_axis_block_packer #(.IN_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .soft_clear(soft_clear),
    .s_axis_tdata(a_tdata), .s_axis_tvalid(a_tvalid), .s_axis_tlast(a_tlast), .s_axis_tready(a_tready),
    .m_axis_tdata(a_m_tdata), .m_axis_tkeep(a_m_tkeep), .m_axis_tvalid(a_m_tvalid), .m_axis_tlast(a_m_tlast),
    .m_axis_tready(a_m_tready), .blk_count(a_blk), .pad_count(a_pad), .busy(a_busy)
  );

  aes_axis_block_packer #(.IN_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .soft_clear(soft_clear),
    .s_axis_tdata(b_tdata), .s_axis_tvalid(b_tvalid), .s_axis_tlast(b_tlast), .s_axis_tready(b_tready),
    .m_axis_tdata(b_m_tdata), .m_axis_tkeep(b_m_tkeep), .m_axis_tvalid(b_m_tvalid), .m_axis_tlast(b_m_tlast),
    .m_axis_tready(b_m_tready), .blk_count(b_blk), .pad_count(b_pad), .busy(b_busy)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one 32-bit beat until accepted, then update the reference model.
  task automatic send32(input logic [31:0] d, input logic last);
    int waited;
    waited = 0;
    a_tdata = d; a_tvalid = 1'b1; a_tlast = last;
    @(negedge clk);
    while (!a_tready && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (waited >= 200) check("a_accept_timeout", 128'd1, 128'd0);
    acc32[127 - k32*32 -: 32] = d;
    if (k32 == 3 || last) begin
      q32.push_back('{d: acc32, k: 16'hFFFF << (16 - (k32 + 1) * 4), l: last});
      acc32 = '0; k32 = 0;
    end else begin
      k32++;
    end
    @(posedge clk); #1;
  endtask

  task automatic send8(input logic [7:0] d, input logic last);
    int waited;
    waited = 0;
    b_tdata = d; b_tvalid = 1'b1; b_tlast = last;
    @(negedge clk);
    while (!b_tready && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (waited >= 200) check("b_accept_timeout", 128'd1, 128'd0);
    acc8[127 - k8*8 -: 8] = d;
    if (k8 == 15 || last) begin
      q8.push_back('{d: acc8, k: 16'hFFFF << (16 - (k8 + 1)), l: last});
      acc8 = '0; k8 = 0;
    end else begin
      k8++;
    end
    @(posedge clk); #1;
  endtask

  // Pulse soft_clear while a stale beat is offered; it must be refused.
  task automatic pulse_clear();
    a_tvalid = 1'b1; a_tdata = 32'hDEADBEEF; a_tlast = 1'b0;
    soft_clear = 1'b1;
    @(negedge clk);
    check("sc_tready", 128'(a_tready), 128'd0);
    @(posedge clk); #1;
    soft_clear = 1'b0; a_tvalid = 1'b0;
    acc32 = '0; k32 = 0;
    check("sc_blk", 128'(a_blk), 128'd0);
    check("sc_pad", 128'(a_pad), 128'd0);
    check("sc_busy", 128'(a_busy), 128'd0);
    check("sc_tvalid", 128'(a_m_tvalid), 128'd0);
  endtask

  // Output monitors: pop the scoreboard on every output handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!gap_en) gap_ok = 1'b0;
    if (rst_n) begin
      cyc32++;
      if (a_m_tvalid && a_m_tready) begin
        if (q32.size() == 0) begin
          check("a_unexpected_block", a_m_tdata, 128'd0);
        end else begin
          e = q32.pop_front();
          check("a_tdata", a_m_tdata, e.d);
          check("a_tkeep", 128'(a_m_tkeep), 128'(e.k));
          check("a_tlast", 128'(a_m_tlast), 128'(e.l));
        end
        if (gap_en) begin
          if (gap_ok) check("a_gap", 128'(cyc32 - prev32), 128'd4);
          gap_ok = 1'b1;
          prev32 = cyc32;
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && b_m_tvalid && b_m_tready) begin
      if (q8.size() == 0) begin
        check("b_unexpected_block", b_m_tdata, 128'd0);
      end else begin
        e = q8.pop_front();
        check("b_tdata", b_m_tdata, e.d);
        check("b_tkeep", 128'(b_m_tkeep), 128'(e.k));
        check("b_tlast", 128'(b_m_tlast), 128'(e.l));
      end
    end
  end

  initial begin
    logic [127:0] held_d;
    logic [15:0]  held_k;

    #12;
    check("rst_tvalid", 128'(a_m_tvalid), 128'd0);
    check("rst_tdata", a_m_tdata, 128'd0);
    check("rst_tkeep", 128'(a_m_tkeep), 128'd0);
    check("rst_blk", 128'(a_blk), 128'd0);
    check("rst_busy", 128'(a_busy), 128'd0);
    check("rst_tready", 128'(a_tready), 128'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: full block, one-cycle latency
    send32(32'h6BC1BEE2, 1'b0);
    send32(32'h2E409F96, 1'b0);
    send32(32'hE93D7E11, 1'b0);
    check("t1_tvalid_before", 128'(a_m_tvalid), 128'd0);
    send32(32'h7393172A, 1'b1);
    a_tvalid = 1'b0;
    check("t1_latency", 128'(a_m_tvalid), 128'd1);
    check("t1_const", a_m_tdata, 128'h6BC1BEE22E409F96E93D7E117393172A);
    repeat (2) @(posedge clk); #1;
    check("t1_blk", 128'(a_blk), 128'd1);

    // 2: padded tail
    send32(32'hAAAAAAAA, 1'b0);
    send32(32'hBBBBBBBB, 1'b1);
    a_tvalid = 1'b0;
    check("t2_keep", 128'(a_m_tkeep), 128'(16'hFF00));
    repeat (2) @(posedge clk); #1;
    check("t2_pad", 128'(a_pad), 128'd1);
    check("t2_blk", 128'(a_blk), 128'd2);

    // 3: backpressure hold
    a_m_tready = 1'b0;
    send32(32'h10000001, 1'b0);
    send32(32'h10000002, 1'b0);
    send32(32'h10000003, 1'b0);
    send32(32'h10000004, 1'b0);
    held_d = 128'h10000001100000021000000310000004;
    held_k = 16'hFFFF;
    a_tdata = 32'h20000001; a_tvalid = 1'b1; a_tlast = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("t3_hold_tready", 128'(a_tready), 128'd0);
      check("t3_hold_tdata", a_m_tdata, held_d);
      check("t3_hold_tkeep", 128'(a_m_tkeep), 128'(held_k));
    end
    @(posedge clk); #1;
    a_m_tready = 1'b1;
    for (int i = 1; i <= 4; i++) send32(32'h20000000 + 32'(i), 1'b0);
    for (int i = 1; i <= 4; i++) send32(32'h30000000 + 32'(i), i == 4);
    a_tvalid = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("t3_blk", 128'(a_blk), 128'd5);

    // 5: soft_clear drops a partial block
    send32(32'hCAFE0001, 1'b0);
    send32(32'hCAFE0002, 1'b0);
    pulse_clear();
    send32(32'h11111111, 1'b0);
    send32(32'h22222222, 1'b0);
    send32(32'h33333333, 1'b0);
    send32(32'h44444444, 1'b1);
    a_tvalid = 1'b0;
    check("t5_const", a_m_tdata, 128'h11111111222222223333333344444444);
    repeat (2) @(posedge clk); #1;
    check("t5_blk", 128'(a_blk), 128'd1);
    check("t5_pad", 128'(a_pad), 128'd0);

    // 4: 64 back-to-back beats
    pulse_clear();
    gap_en = 1'b1;
    for (int i = 1; i <= 64; i++) send32(32'hB0000000 + 32'(i), i == 64);
    a_tvalid = 1'b0;
    repeat (3) @(posedge clk); #1;
    gap_en = 1'b0;
    check("t4_blk", 128'(a_blk), 128'd16);
    check("t4_pad", 128'(a_pad), 128'd0);

    // 6: 8-bit instance, padded block then reset mid-block
    for (int i = 1; i <= 5; i++) send8(8'(i), i == 5);
    b_tvalid = 1'b0;
    check("t6_const", b_m_tdata, {40'h0102030405, 88'd0});
    check("t6_keep", 128'(b_m_tkeep), 128'(16'hF800));
    repeat (2) @(posedge clk); #1;
    check("t6_pad", 128'(b_pad), 128'd1);
    send8(8'h06, 1'b0);
    send8(8'h07, 1'b0);
    send8(8'h08, 1'b0);
    b_tvalid = 1'b0;
    #2 rst_n = 1'b0;
    acc8 = '0; k8 = 0;
    #1;
    check("t6_rst_tvalid", 128'(b_m_tvalid), 128'd0);
    check("t6_rst_tdata", b_m_tdata, 128'd0);
    check("t6_rst_tkeep", 128'(b_m_tkeep), 128'd0);
    check("t6_rst_blk", 128'(b_blk), 128'd0);
    check("t6_rst_pad", 128'(b_pad), 128'd0);
    check("t6_rst_busy", 128'(b_busy), 128'd0);
    check("t6_rst_tready", 128'(b_tready), 128'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk); #1;
    check("t6_no_block", 128'(b_blk), 128'd0);
    check("t6_idle_busy", 128'(b_busy), 128'd0);

    check("q32_drained", 128'(q32.size()), 128'd0);
    check("q8_drained", 128'(q8.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
